// File: rtl/ps2_pkg.sv
// ps2_pkg: scancode constants and receiver state encoding shared by the PS/2 key decoder.
package ps2_pkg;
  localparam logic [7:0] SC_BREAK  = 8'hF0;
  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_BKSP   = 8'h66;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;
endpackage

// File: rtl/scancode_to_ascii.sv
// scancode_to_ascii: combinational set-2 make code to ASCII lookup; 0x00 for anything non-printable.
module scancode_to_ascii (
  input  logic [7:0] code,
  input  logic       shift,
  input  logic       caps,
  output logic [7:0] ascii
);
  logic [7:0] lo, hi;
  logic letter;
  always_comb begin
    {lo, hi} = 16'h0;
    case (code)
      8'h1C: lo = "a"; 8'h32: lo = "b"; 8'h21: lo = "c"; 8'h23: lo = "d";
      8'h24: lo = "e"; 8'h2B: lo = "f"; 8'h34: lo = "g"; 8'h33: lo = "h";
      8'h43: lo = "i"; 8'h3B: lo = "j"; 8'h42: lo = "k"; 8'h4B: lo = "l";
      8'h3A: lo = "m"; 8'h31: lo = "n"; 8'h44: lo = "o"; 8'h4D: lo = "p";
      8'h15: lo = "q"; 8'h2D: lo = "r"; 8'h1B: lo = "s"; 8'h2C: lo = "t";
      8'h3C: lo = "u"; 8'h2A: lo = "v"; 8'h1D: lo = "w"; 8'h22: lo = "x";
      8'h35: lo = "y"; 8'h1A: lo = "z"; 8'h29: lo = " ";
      8'h16: {lo, hi} = {"1", "!"}; 8'h1E: {lo, hi} = {"2", "@"};
      8'h26: {lo, hi} = {"3", "#"}; 8'h25: {lo, hi} = {"4", "$"};
      8'h2E: {lo, hi} = {"5", "%"}; 8'h36: {lo, hi} = {"6", "^"};
      8'h3D: {lo, hi} = {"7", "&"}; 8'h3E: {lo, hi} = {"8", "*"};
      8'h46: {lo, hi} = {"9", "("}; 8'h45: {lo, hi} = {"0", ")"};
      8'h0E: {lo, hi} = {8'h60, "~"}; 8'h4E: {lo, hi} = {"-", "_"};
      8'h55: {lo, hi} = {"=", "+"}; 8'h54: {lo, hi} = {"[", "{"};
      8'h5B: {lo, hi} = {"]", "}"}; 8'h5D: {lo, hi} = {"\\", "|"};
      8'h4C: {lo, hi} = {";", ":"}; 8'h52: {lo, hi} = {"'", "\""};
      8'h41: {lo, hi} = {",", "<"}; 8'h49: {lo, hi} = {".", ">"};
      8'h4A: {lo, hi} = {"/", "?"};
      default: {lo, hi} = 16'h0;
    endcase
    letter = lo >= "a" && lo <= "z";
    ascii = letter ? ((shift ^ caps) ? lo - 8'h20 : lo) : ((shift && hi != 8'h00) ? hi : lo);
  end
endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: PS/2 deframer, scancode FIFO and make/break decoder producing rate-limited key events.
module ps2_key_decoder
  import ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000,
  parameter int KEY_GAP    = 4
) (
  input  logic       mainclk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       new_key,
  output logic [7:0] current_key,
  output logic [7:0] ascii_key,
  output logic       key_ext,
  output logic       shift,
  output logic       caps_lock,
  output logic       rx_err,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(KEY_GAP + 1);
  logic c1, c2, d1, d2, clk_f, fe;
  logic [1:0] lo_cnt;
  rx_state_t state_q, state_d;
  logic [2:0] bit_cnt;
  logic [7:0] sr, push_data, head, asc;
  logic par, push_q, timeout, stop_fe, good;
  logic [TW-1:0] to_cnt;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic empty, full, wr, pop, is_pre, is_ev, brk, ext, lsh, rsh, gap_done;
  logic [GW-1:0] gap_cnt;
  // clk_f is the filtered line level; an edge counts only after three consecutive low samples
  assign fe = clk_f && !c2 && lo_cnt == 2'd2;
  always_ff @(posedge mainclk) begin
    if (reset) begin
      {c1, c2, d1, d2, clk_f} <= 5'b00110;
      lo_cnt <= 2'd0;
    end else begin
      {c1, c2, d1, d2} <= {ps2_clk, c1, ps2_data, d1};
      lo_cnt <= c2 ? 2'd0 : (lo_cnt == 2'd3 ? 2'd3 : lo_cnt + 2'd1);
      clk_f <= c2 ? 1'b1 : (fe ? 1'b0 : clk_f);
    end
  end
  assign timeout = state_q != RX_IDLE && to_cnt == TW'(TIMEOUT);
  assign stop_fe = fe && state_q == RX_STOP && !timeout;
  assign good = d2 && ^{sr, par};
  always_comb begin
    state_d = state_q;
    if (timeout) state_d = RX_IDLE;
    else if (fe)
      case (state_q)
        RX_IDLE:   state_d = d2 ? RX_IDLE : RX_DATA;
        RX_DATA:   state_d = bit_cnt == 3'd7 ? RX_PARITY : RX_DATA;
        RX_PARITY: state_d = RX_STOP;
        default:   state_d = RX_IDLE;
      endcase
  end
  always_ff @(posedge mainclk) begin
    if (reset) begin
      state_q <= RX_IDLE;
      {bit_cnt, sr, push_data, par, push_q, rx_err} <= '0;
      to_cnt <= '0;
    end else begin
      state_q <= state_d;
      to_cnt <= (state_q == RX_IDLE || fe || timeout) ? '0 : to_cnt + TW'(1);
      if (state_q == RX_IDLE) bit_cnt <= 3'd0;
      if (fe && state_q == RX_DATA) {sr, bit_cnt} <= {d2, sr[7:1], bit_cnt + 3'd1};
      if (fe && state_q == RX_PARITY) par <= d2;
      if (stop_fe) push_data <= sr;
      push_q <= stop_fe && good;
      rx_err <= stop_fe && !good;
    end
  end
  assign empty = wp == rp;
  assign full = (wp ^ rp) == {1'b1, {AW{1'b0}}};
  assign head = mem[rp[AW-1:0]];
  assign wr = push_q && (!full || pop);
  always_ff @(posedge mainclk) if (wr) mem[wp[AW-1:0]] <= push_data;
  always_ff @(posedge mainclk) begin
    if (reset) begin
      {wp, rp} <= '0;
      overflow <= 1'b0;
    end else begin
      wp <= wp + {{AW{1'b0}}, wr};
      rp <= rp + {{AW{1'b0}}, pop};
      overflow <= overflow | (push_q && !wr);
    end
  end
  // only key events wait out the gap; prefixes and modifiers drain immediately
  assign is_pre = head == SC_EXT || head == SC_BREAK;
  assign is_ev = !is_pre && !brk && head != SC_LSHIFT && head != SC_RSHIFT && head != SC_CAPS;
  assign gap_done = gap_cnt == GW'(KEY_GAP);
  assign pop = !empty && (gap_done || !is_ev);
  assign shift = lsh | rsh;
  scancode_to_ascii u_asc (.code(head), .shift(shift), .caps(caps_lock), .ascii(asc));
  always_ff @(posedge mainclk) begin
    if (reset) begin
      {new_key, current_key, ascii_key, key_ext, caps_lock, lsh, rsh, brk, ext} <= '0;
      gap_cnt <= GW'(KEY_GAP);
    end else begin
      new_key <= pop && is_ev;
      gap_cnt <= (pop && is_ev) ? GW'(1) : (gap_done ? gap_cnt : gap_cnt + GW'(1));
      if (pop) begin
        ext <= is_pre && (ext || head == SC_EXT);
        brk <= is_pre && (brk || head == SC_BREAK);
        if (!ext && head == SC_LSHIFT) lsh <= !brk;
        if (!ext && head == SC_RSHIFT) rsh <= !brk;
        if (!brk && head == SC_CAPS) caps_lock <= !caps_lock;
        if (is_ev) {current_key, ascii_key, key_ext} <= {head, ext ? 8'h00 : asc, ext};
      end
    end
  end
endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives the raw PS/2 keyboard serial stream, deframes it into scancode bytes, buffers them, and decodes make/break/extended sequences into single-cycle key events. It sits directly upstream of the VGA text-terminal input stage. That stage consumes `new_key`, `current_key` (raw make code; it tests 0x66 for backspace and 0x5A for enter) and `ascii_key` (0x00 means non-printable).

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: scancode byte buffer entries (power of two).
- `TIMEOUT`, default 50000: `mainclk` cycles without a PS/2 falling edge before a partial frame is discarded.
- `KEY_GAP`, default 4: minimum `mainclk` cycles between `new_key` pulses. The consumer needs 3 cycles per key.

Ports:
- `mainclk` in 1: system clock.
- `reset` in 1: reset, synchronous, active-high; clock mainclk.
- `ps2_clk` in 1: asynchronous PS/2 clock from the keyboard.
- `ps2_data` in 1: asynchronous PS/2 data.
- `new_key` out 1: one-cycle pulse; a key make event is valid.
- `current_key` out 8: make code of the last event; held until the next event.
- `ascii_key` out 8: ASCII of the last event; 0x00 if non-printable. Held with `current_key`.
- `key_ext` out 1: the last event was E0-prefixed.
- `shift` out 1: either shift key is held.
- `caps_lock` out 1: caps-lock toggle state.
- `rx_err` out 1: one-cycle pulse on a parity or stop-bit error.
- `overflow` out 1: sticky flag; a byte was dropped because the FIFO was full.

## Operation
- **Sync and filter:** 2-FF synchronizer on both inputs. `ps2_clk` must be stable low for 3 samples after being high before a falling edge `fe` registers.
- **Receiver FSM:**
  - IDLE: on `fe` with data=0 → DATA, bit count 0. On `fe` with data=1, stay IDLE (spurious edge).
  - DATA: 8 bits LSB-first on `fe` → PARITY.
  - PARITY: sample on `fe` → STOP.
  - STOP: sample on `fe`. If the stop bit is 1 and odd parity holds, push the byte. Otherwise pulse `rx_err` and drop the byte. Return to IDLE.
  - In any non-IDLE state, a timeout counter reaching `TIMEOUT` forces IDLE with no error pulse. The counter clears on every `fe`.
- **FIFO:** write on a good frame. If the FIFO is full, drop the byte and set `overflow`. Pop when the decoder is ready and the FIFO is non-empty.
- **Decoder:** flags `brk` and `ext`, both cleared after each non-prefix byte.
  - 0xE0 sets `ext`. 0xF0 sets `brk`.
  - 0x12 or 0x59 (shift): make sets, break clears the respective shift bit. `shift` is the OR of the two. E0 12 and E0 59 are ignored.
  - 0x58 (caps lock): make toggles `caps_lock`; break is ignored.
  - Any other make: latch `current_key`, `ascii_key` and `key_ext`, then pulse `new_key`.
  - Any other break: no event.
  - Typematic repeats produce an event per make code.
- **ASCII mapping:** letters are uppercase iff `shift` XOR `caps_lock`. Digits and punctuation use the shifted glyph iff `shift`. Space is 0x20.
  - 0x66 (backspace), 0x5A (enter) and every extended key map to 0x00.
  - Unmapped codes map to 0x00 and still emit an event.

## Timing
- All outputs reset to 0: `new_key`, `current_key`, `ascii_key`, `key_ext`, `shift`, `caps_lock`, `rx_err`, `overflow`. Receiver → IDLE, FIFO empty, `brk`/`ext` cleared, gap counter = `KEY_GAP` (ready).
- `fe` is detected 4–5 cycles after the pad edge (2 sync + 3 filter).
- Stop bit `fe` in cycle N → FIFO write in N+1 → pop no earlier than N+2 → `new_key` in N+3 for an empty FIFO with the gap elapsed.
- After a `new_key` pulse, the next pulse comes no earlier than `KEY_GAP` cycles later. Prefix and modifier bytes are consumed at one per cycle with no gap.
- A simultaneous FIFO write and pop is legal at any occupancy. On full with a simultaneous pop, the write succeeds.
- `rx_err` and `new_key` may assert in the same cycle.
- Reset mid-frame discards the frame and all FIFO contents.

## Structure
- Package `ps2_pkg`:
  - scancode constants: `SC_BREAK`=F0, `SC_EXT`=E0, `SC_LSHIFT`=12, `SC_RSHIFT`=59, `SC_CAPS`=58, `SC_BKSP`=66, `SC_ENTER`=5A.
  - receiver state enum.
- Sub-module `scancode_to_ascii`: purely combinational lookup taking (code, shift, caps) → ascii. It sits beside the top, which holds the sync, receiver, FIFO and decoder.

## Test plan
- Frame 0x1C with good parity (F0 1C follows) → one `new_key`, `current_key`=0x1C, `ascii_key`=0x61 ('a'); no event for the break.
- 12, 1C, F0 1C, F0 12 → `ascii_key`=0x41. Then 58, F0 58, 1C → `caps_lock`=1, `ascii_key`=0x41. Then shift + 1C → 0x61.
- Frame 0x66 with bad parity → `rx_err` pulse, no event. Repeat with good parity → `current_key`=0x66, `ascii_key`=0x00.
- E0 75 → `new_key`, `key_ext`=1, `ascii_key`=0x00. Abort a frame after 4 bits, wait `TIMEOUT`+1 cycles, send 0x5A → a clean event with `current_key`=0x5A.
- Hold the decoder off with a long burst of `FIFO_DEPTH`+2 bytes → `overflow`=1, exactly `FIFO_DEPTH` events, consecutive `new_key` pulses ≥`KEY_GAP` apart.
- Assert reset mid-frame → all outputs 0; the next full frame decodes correctly.
